// File: rtl/seq_ctrl_ws_pkg.sv
// rtl/seq_ctrl_ws_pkg.sv - shared types for the wait-state sequencer controller
package seq_ctrl_ws_pkg;

  typedef enum logic [2:0] {
    HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3,
    XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7
  } opcode_t;

  // Encodings 0..7 double as the phase index driven on the phase output.
  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0, INST_FETCH = 4'd1, INST_LOAD = 4'd2, IDLE   = 4'd3,
    OP_ADDR    = 4'd4, OP_FETCH   = 4'd5, ALU_OP    = 4'd6, STORE  = 4'd7,
    HALTED     = 4'd8, PAUSED     = 4'd9
  } ctrl_state_t;

  function automatic logic is_aluop(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// rtl/seq_wait_timer.sv - consecutive stall counter with expiry on the stall that would reach MAX_WAIT
module seq_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic rst_,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] wait_cnt;

  assign expired = count && (wait_cnt == LAST);

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_)
      wait_cnt <= '0;
    else if (clear || expired)
      wait_cnt <= '0;
    else if (count)
      wait_cnt <= wait_cnt + 1'b1;
  end

endmodule

// File: rtl/seq_ctrl_ws.sv
// rtl/seq_ctrl_ws.sv - 8-phase CPU sequencer with memory wait states, timeout, halt/resume and single-step
module seq_ctrl_ws
  import seq_ctrl_ws_pkg::*;
#(
  parameter int MAX_WAIT        = 15,
  parameter int HALT_ON_TIMEOUT = 1
) (
  input  logic    clk,
  input  logic    rst_,
  input  opcode_t opcode,
  input  logic    zero,
  input  logic    mem_ready,
  input  logic    step_mode,
  input  logic    resume,
  output logic    mem_rd,
  output logic    load_ir,
  output logic    inc_pc,
  output logic    load_ac,
  output logic    load_pc,
  output logic    mem_wr,
  output logic    halt,
  output logic [2:0] phase,
  output logic    timeout_err
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  ctrl_state_t state, state_n, adv_state;
  logic        hold_req, held, expired, supp;
  logic        aluop;

  assign aluop = is_aluop(opcode);
  assign held  = hold_req && !expired;

  seq_wait_timer #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_timer (
    .clk     (clk),
    .rst_    (rst_),
    .clear   (!hold_req),
    .count   (hold_req),
    .expired (expired)
  );

  always_comb begin
    hold_req = 1'b0;
    case (state)
      INST_LOAD: hold_req = !mem_ready;
      ALU_OP:    hold_req = aluop && !mem_ready;
      STORE:     hold_req = (opcode == STO) && !mem_ready;
      default:   hold_req = 1'b0;
    endcase
  end

  always_comb begin
    adv_state = ctrl_state_t'(state + 4'd1);
    if (state == STORE)
      adv_state = step_mode ? PAUSED : INST_ADDR;
    state_n = state;
    if (state == HALTED || state == PAUSED) begin
      if (resume)
        state_n = INST_ADDR;
    end else if (held) begin
      state_n = state;
    end else if (expired && (HALT_ON_TIMEOUT != 0)) begin
      state_n = HALTED;
    end else if (state == OP_ADDR && opcode == HLT) begin
      state_n = HALTED;
    end else begin
      state_n = adv_state;
    end
  end

  // supp blanks the load strobe of the phase entered by a forced (timed-out) advance.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state       <= INST_ADDR;
      timeout_err <= 1'b0;
      supp        <= 1'b0;
    end else begin
      state <= state_n;
      supp  <= expired && (HALT_ON_TIMEOUT == 0);
      if (expired)
        timeout_err <= 1'b1;
    end
  end

  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    halt    = 1'b0;
    phase   = 3'd7;
    if (state != HALTED && state != PAUSED)
      phase = state[2:0];
    case (state)
      INST_FETCH: mem_rd = 1'b1;
      INST_LOAD: begin
        mem_rd  = 1'b1;
        load_ir = mem_ready;
      end
      IDLE: begin
        mem_rd  = 1'b1;
        load_ir = !supp;
      end
      OP_ADDR:  inc_pc = 1'b1;
      OP_FETCH: mem_rd = aluop;
      ALU_OP: begin
        mem_rd  = aluop;
        load_ac = aluop && mem_ready;
        inc_pc  = (opcode == SKZ) && zero && !hold_req;
        load_pc = (opcode == JMP) && !hold_req;
      end
      STORE: begin
        mem_rd  = aluop;
        load_ac = aluop && !supp;
        inc_pc  = (opcode == JMP) && !hold_req;
        load_pc = (opcode == JMP) && !hold_req;
        mem_wr  = (opcode == STO);
      end
      HALTED:  halt = 1'b1;
      default: ;
    endcase
    if (rst_) begin
      mem_rd  = 1'b0;
      load_ir = 1'b0;
      inc_pc  = 1'b0;
      load_ac = 1'b0;
      load_pc = 1'b0;
      mem_wr  = 1'b0;
      halt    = 1'b0;
      phase   = 3'd0;
    end
  end

endmodule

// File: tb/tb_seq_ctrl_ws.sv
// tb/tb_seq_ctrl_ws.sv - directed vector bench for seq_ctrl_ws (timeout-halting and timeout-advancing instances)
module tb_seq_ctrl_ws;
  import seq_ctrl_ws_pkg::*;

  typedef struct {
    opcode_t    op;
    logic       rdy;
    logic       z;
    logic       step;
    logic       res;
    logic [2:0] ph;
    logic [5:0] st;   // {mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr}
    logic       hlt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  opcode_t opcode = ADD;
  logic zero = 1'b0, mem_ready = 1'b1, step_mode = 1'b0, resume = 1'b0;

  logic mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr, halt, timeout_err;
  logic [2:0] phase;
  logic mem_rd_b, load_ir_b, inc_pc_b, load_ac_b, load_pc_b, mem_wr_b, halt_b, timeout_err_b;
  logic [2:0] phase_b;

  int n_checks = 0;
  int n_fail = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  seq_ctrl_ws #(.MAX_WAIT(4), .HALT_ON_TIMEOUT(1)) dut (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .step_mode(step_mode), .resume(resume), .mem_rd(mem_rd), .load_ir(load_ir),
    .inc_pc(inc_pc), .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr),
    .halt(halt), .phase(phase), .timeout_err(timeout_err)
  );

  seq_ctrl_ws #(.MAX_WAIT(4), .HALT_ON_TIMEOUT(0)) dut_b (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .step_mode(step_mode), .resume(resume), .mem_rd(mem_rd_b), .load_ir(load_ir_b),
    .inc_pc(inc_pc_b), .load_ac(load_ac_b), .load_pc(load_pc_b), .mem_wr(mem_wr_b),
    .halt(halt_b), .phase(phase_b), .timeout_err(timeout_err_b)
  );

  logic [7:0] st_a, st_b;
  assign st_a = {2'b00, mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr};
  assign st_b = {2'b00, mem_rd_b, load_ir_b, inc_pc_b, load_ac_b, load_pc_b, mem_wr_b};

  function automatic vec_t mk(opcode_t op, logic rdy, logic z, logic step, logic res,
                              logic [2:0] ph, logic [5:0] st, logic hlt);
    vec_t v;
    v.op = op; v.rdy = rdy; v.z = z; v.step = step; v.res = res;
    v.ph = ph; v.st = st; v.hlt = hlt;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, check both instances' decode, then step to the next cycle.
  task automatic apply(input vec_t v, input string tag);
    opcode = v.op; mem_ready = v.rdy; zero = v.z; step_mode = v.step; resume = v.res;
    #1;
    check({tag, ".phase"},  {5'd0, phase},   {5'd0, v.ph});
    check({tag, ".strobe"}, st_a,            {2'b00, v.st});
    check({tag, ".halt"},   {7'd0, halt},    {7'd0, v.hlt});
    check({tag, ".phase_b"},  {5'd0, phase_b}, {5'd0, v.ph});
    check({tag, ".strobe_b"}, st_b,            {2'b00, v.st});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst_ = 1'b1; resume = 1'b0; step_mode = 1'b0; mem_ready = 1'b1; zero = 1'b0;
    #1;
    check({tag, ".rst_phase"}, {5'd0, phase}, 8'd0);
    check({tag, ".rst_strobe"}, st_a, 8'd0);
    check({tag, ".rst_halt"}, {7'd0, halt}, 8'd0);
    check({tag, ".rst_terr"}, {7'd0, timeout_err}, 8'd0);
    check({tag, ".rst_terr_b"}, {7'd0, timeout_err_b}, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_ = 1'b0;
  endtask

  task automatic fetch_part(input opcode_t op, input logic z, input logic step, input string tag);
    apply(mk(op, 1, z, step, 0, 3'd0, 6'b000000, 0), tag);
    apply(mk(op, 1, z, step, 0, 3'd1, 6'b100000, 0), tag);
    apply(mk(op, 1, z, step, 0, 3'd2, 6'b110000, 0), tag);
    apply(mk(op, 1, z, step, 0, 3'd3, 6'b110000, 0), tag);
    apply(mk(op, 1, z, step, 0, 3'd4, 6'b001000, 0), tag);
  endtask

  initial begin
    int ac_cnt;

    // Full instructions with memory always ready: ADD, JMP, STO, SKZ (zero=0).
    vecs.push_back(mk(ADD, 1, 0, 0, 0, 3'd0, 6'b000000, 0));
    vecs.push_back(mk(ADD, 1, 0, 0, 0, 3'd1, 6'b100000, 0));
    vecs.push_back(mk(ADD, 1, 0, 0, 0, 3'd2, 6'b110000, 0));
    vecs.push_back(mk(ADD, 1, 0, 0, 0, 3'd3, 6'b110000, 0));
    vecs.push_back(mk(ADD, 1, 0, 0, 0, 3'd4, 6'b001000, 0));
    vecs.push_back(mk(ADD, 1, 0, 0, 0, 3'd5, 6'b100000, 0));
    vecs.push_back(mk(ADD, 1, 0, 0, 0, 3'd6, 6'b100100, 0));
    vecs.push_back(mk(ADD, 1, 0, 0, 0, 3'd7, 6'b100100, 0));
    vecs.push_back(mk(JMP, 1, 0, 0, 0, 3'd0, 6'b000000, 0));
    vecs.push_back(mk(JMP, 1, 0, 0, 1, 3'd1, 6'b100000, 0));
    vecs.push_back(mk(JMP, 1, 0, 0, 0, 3'd2, 6'b110000, 0));
    vecs.push_back(mk(JMP, 1, 0, 0, 0, 3'd3, 6'b110000, 0));
    vecs.push_back(mk(JMP, 1, 0, 0, 0, 3'd4, 6'b001000, 0));
    vecs.push_back(mk(JMP, 1, 0, 0, 0, 3'd5, 6'b000000, 0));
    vecs.push_back(mk(JMP, 1, 0, 0, 0, 3'd6, 6'b000010, 0));
    vecs.push_back(mk(JMP, 1, 0, 0, 0, 3'd7, 6'b001010, 0));
    vecs.push_back(mk(STO, 1, 0, 0, 0, 3'd0, 6'b000000, 0));
    vecs.push_back(mk(STO, 1, 0, 0, 0, 3'd1, 6'b100000, 0));
    vecs.push_back(mk(STO, 0, 0, 0, 0, 3'd2, 6'b100000, 0));
    vecs.push_back(mk(STO, 1, 0, 0, 0, 3'd2, 6'b110000, 0));
    vecs.push_back(mk(STO, 1, 0, 0, 0, 3'd3, 6'b110000, 0));
    vecs.push_back(mk(STO, 1, 0, 0, 0, 3'd4, 6'b001000, 0));
    vecs.push_back(mk(STO, 0, 0, 0, 0, 3'd5, 6'b000000, 0));
    vecs.push_back(mk(STO, 0, 0, 0, 0, 3'd6, 6'b000000, 0));
    vecs.push_back(mk(STO, 1, 0, 0, 0, 3'd7, 6'b000001, 0));
    vecs.push_back(mk(SKZ, 1, 0, 0, 0, 3'd0, 6'b000000, 0));
    vecs.push_back(mk(SKZ, 1, 0, 0, 0, 3'd1, 6'b100000, 0));
    vecs.push_back(mk(SKZ, 1, 0, 0, 0, 3'd2, 6'b110000, 0));
    vecs.push_back(mk(SKZ, 1, 0, 0, 0, 3'd3, 6'b110000, 0));
    vecs.push_back(mk(SKZ, 1, 0, 0, 0, 3'd4, 6'b001000, 0));
    vecs.push_back(mk(SKZ, 1, 0, 0, 0, 3'd5, 6'b000000, 0));
    vecs.push_back(mk(SKZ, 0, 0, 0, 0, 3'd6, 6'b000000, 0));
    vecs.push_back(mk(SKZ, 1, 0, 0, 0, 3'd7, 6'b000000, 0));
    vecs.push_back(mk(ADD, 1, 0, 0, 0, 3'd0, 6'b000000, 0));

    do_reset("t1");
    foreach (vecs[i]) apply(vecs[i], $sformatf("t1.v%0d", i));

    // LDA stalls three cycles in ALU_OP; load_ac fires once, in the ready cycle.
    do_reset("t2");
    fetch_part(LDA, 0, 0, "t2");
    apply(mk(LDA, 1, 0, 0, 0, 3'd5, 6'b100000, 0), "t2");
    ac_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      opcode = LDA; mem_ready = (i == 3); #1;
      ac_cnt += int'(load_ac);
      check($sformatf("t2.hold%0d.phase", i), {5'd0, phase}, 8'd6);
      check($sformatf("t2.hold%0d.strobe", i), st_a, (i == 3) ? 8'b00100100 : 8'b00100000);
      @(posedge clk); #1;
    end
    check("t2.load_ac_count", 8'(ac_cnt), 8'd1);
    apply(mk(LDA, 1, 0, 0, 0, 3'd7, 6'b100100, 0), "t2");

    // INST_LOAD never ready: timeout on the fourth stall.
    do_reset("t3");
    apply(mk(ADD, 1, 0, 0, 0, 3'd0, 6'b000000, 0), "t3");
    apply(mk(ADD, 1, 0, 0, 0, 3'd1, 6'b100000, 0), "t3");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3.stall%0d.terr", i), {7'd0, timeout_err}, 8'd0);
      apply(mk(ADD, 0, 0, 0, 0, 3'd2, 6'b100000, 0), $sformatf("t3.stall%0d", i));
    end
    mem_ready = 1'b0; #1;
    check("t3.terr", {7'd0, timeout_err}, 8'd1);
    check("t3.halt", {7'd0, halt}, 8'd1);
    check("t3.halt_phase", {5'd0, phase}, 8'd7);
    check("t3.halt_strobe", st_a, 8'd0);
    check("t3.terr_b", {7'd0, timeout_err_b}, 8'd1);
    check("t3.phase_b", {5'd0, phase_b}, 8'd3);
    check("t3.strobe_b", st_b, 8'b00100000);
    check("t3.halt_b", {7'd0, halt_b}, 8'd0);
    @(posedge clk); #1;
    check("t3.next_phase_b", {5'd0, phase_b}, 8'd4);
    check("t3.still_halt", {7'd0, halt}, 8'd1);

    // HLT: halted for 20 cycles, then resume restarts the fetch.
    do_reset("t4");
    fetch_part(HLT, 0, 0, "t4");
    for (int i = 0; i < 20; i++) begin
      opcode = HLT; resume = 1'b0; #1;
      check($sformatf("t4.h%0d.halt", i), {7'd0, halt}, 8'd1);
      check($sformatf("t4.h%0d.phase", i), {5'd0, phase}, 8'd7);
      check($sformatf("t4.h%0d.strobe", i), st_a, 8'd0);
      @(posedge clk); #1;
    end
    resume = 1'b1; #1;
    check("t4.resume_cycle_halt", {7'd0, halt}, 8'd1);
    @(posedge clk); #1;
    resume = 1'b0; #1;
    check("t4.after_resume_phase", {5'd0, phase}, 8'd0);
    check("t4.after_resume_halt", {7'd0, halt}, 8'd0);

    // Single-step SKZ with zero=1, pause, resume together with step_mode, pause again.
    do_reset("t5");
    fetch_part(SKZ, 1, 1, "t5");
    apply(mk(SKZ, 1, 1, 1, 0, 3'd5, 6'b000000, 0), "t5");
    apply(mk(SKZ, 1, 1, 1, 0, 3'd6, 6'b001000, 0), "t5");
    apply(mk(SKZ, 1, 1, 1, 0, 3'd7, 6'b000000, 0), "t5");
    for (int i = 0; i < 3; i++)
      apply(mk(SKZ, 1, 1, 1, 0, 3'd7, 6'b000000, 0), $sformatf("t5.pause%0d", i));
    apply(mk(SKZ, 1, 1, 1, 1, 3'd7, 6'b000000, 0), "t5.resume");
    fetch_part(ADD, 1, 1, "t5.run2");
    apply(mk(ADD, 1, 1, 1, 0, 3'd5, 6'b100000, 0), "t5.run2");
    apply(mk(ADD, 1, 1, 1, 0, 3'd6, 6'b100100, 0), "t5.run2");
    apply(mk(ADD, 1, 1, 1, 0, 3'd7, 6'b100100, 0), "t5.run2");
    apply(mk(ADD, 1, 1, 1, 0, 3'd7, 6'b000000, 0), "t5.pause2");
    apply(mk(ADD, 1, 1, 0, 1, 3'd7, 6'b000000, 0), "t5.resume2");
    apply(mk(ADD, 1, 1, 0, 0, 3'd0, 6'b000000, 0), "t5.refetch");

    // Reset asserted in the middle of an STO write stall.
    do_reset("t6");
    fetch_part(STO, 0, 0, "t6");
    apply(mk(STO, 1, 0, 0, 0, 3'd5, 6'b000000, 0), "t6");
    apply(mk(STO, 1, 0, 0, 0, 3'd6, 6'b000000, 0), "t6");
    apply(mk(STO, 0, 0, 0, 0, 3'd7, 6'b000001, 0), "t6.hold0");
    apply(mk(STO, 0, 0, 0, 0, 3'd7, 6'b000001, 0), "t6.hold1");
    check("t6.pre_rst_mem_wr", {7'd0, mem_wr}, 8'd1);
    rst_ = 1'b1; #1;
    check("t6.async_mem_wr", {7'd0, mem_wr}, 8'd0);
    check("t6.async_mem_wr_b", {7'd0, mem_wr_b}, 8'd0);
    check("t6.async_phase", {5'd0, phase}, 8'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_ = 1'b0; #1;
    check("t6.post_phase", {5'd0, phase}, 8'd0);
    check("t6.post_terr", {7'd0, timeout_err}, 8'd0);
    @(posedge clk); #1;
    apply(mk(STO, 1, 0, 0, 0, 3'd1, 6'b100000, 0), "t6.restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
